// File: rtl/branch_resolution_unit.sv
// Execute-side branch resolution: carries fetch predictions through a D/E shadow
// pipeline, checks them against the resolved outcome and issues flush/redirect.
module branch_resolution_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_f,
    input  logic [DATA_WIDTH-1:0] pc_f,
    input  logic                  predict_taken_f,
    input  logic [DATA_WIDTH-1:0] pred_target_f,
    input  logic                  stall_d,
    input  logic                  is_branch_e,
    input  logic                  is_jal_e,
    input  logic                  is_jalr_e,
    input  logic                  cond_taken_e,
    input  logic [DATA_WIDTH-1:0] target_e,
    output logic                  mispredict_e,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush_fd,
    output logic                  flush_de,
    output logic [DATA_WIDTH-1:0] branch_count,
    output logic [DATA_WIDTH-1:0] mispredict_count
);

    logic                  r_valid_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic                  r_ptaken_d;
    logic [DATA_WIDTH-1:0] r_ptarget_d;

    logic                  r_valid_e;
    logic [DATA_WIDTH-1:0] r_pc_e;
    logic                  r_ptaken_e;
    logic [DATA_WIDTH-1:0] r_ptarget_e;

    logic [DATA_WIDTH-1:0] r_branch_count;
    logic [DATA_WIDTH-1:0] r_mispredict_count;

    logic                  w_actual_taken;
    logic                  w_control;
    logic                  w_mispredict;
    logic [DATA_WIDTH-1:0] w_redirect_pc;

    always_comb begin
        w_actual_taken = is_jal_e | is_jalr_e | (is_branch_e & cond_taken_e);
        w_control      = is_branch_e | is_jal_e | is_jalr_e;
        w_mispredict   = r_valid_e &
                         ((w_actual_taken != r_ptaken_e) |
                          (w_actual_taken & r_ptaken_e & (target_e != r_ptarget_e)));
        w_redirect_pc  = '0;
        if (w_mispredict) begin
            // Not-taken correction falls through; the add wraps naturally at the top of memory.
            w_redirect_pc = w_actual_taken ? target_e : (r_pc_e + DATA_WIDTH'(4));
        end
    end

    // Flush takes priority over stall so a wrong-path instruction held in D is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_d   <= 1'b0;
            r_pc_d      <= '0;
            r_ptaken_d  <= 1'b0;
            r_ptarget_d <= '0;
            r_valid_e   <= 1'b0;
            r_pc_e      <= '0;
            r_ptaken_e  <= 1'b0;
            r_ptarget_e <= '0;
        end else if (w_mispredict) begin
            r_valid_d <= 1'b0;
            r_valid_e <= 1'b0;
        end else if (stall_d) begin
            r_valid_e <= 1'b0;
        end else begin
            r_valid_d   <= valid_f;
            r_pc_d      <= pc_f;
            r_ptaken_d  <= predict_taken_f;
            r_ptarget_d <= pred_target_f;
            r_valid_e   <= r_valid_d;
            r_pc_e      <= r_pc_d;
            r_ptaken_e  <= r_ptaken_d;
            r_ptarget_e <= r_ptarget_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (r_valid_e && w_control) begin
                r_branch_count <= r_branch_count + DATA_WIDTH'(1);
            end
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + DATA_WIDTH'(1);
            end
        end
    end

    assign mispredict_e     = w_mispredict;
    assign redirect_pc      = w_redirect_pc;
    assign flush_fd         = w_mispredict;
    assign flush_de         = w_mispredict;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Execute-side counterpart of the fetch-stage static predictor.
- Carries each fetch-stage prediction (taken flag, predicted target, PC) through its own F→D→E shadow pipeline.
- In execute, compares the prediction against the resolved outcome; on a wrong prediction it flushes the younger stages and supplies the corrected fetch PC.
- Keeps branch and mispredict event counters for performance analysis.

Parameters:
DATA_WIDTH, 32, width of PCs, targets and counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
valid_f  input  1  fetch stage holds a real instruction
pc_f  input  DATA_WIDTH  PC of fetched instruction
predict_taken_f  input  1  fetch-stage prediction
pred_target_f  input  DATA_WIDTH  fetch-stage predicted target
stall_d  input  1  hazard unit: hold F/D, insert bubble into E
is_branch_e  input  1  E instruction is conditional branch
is_jal_e  input  1  E instruction is JAL
is_jalr_e  input  1  E instruction is JALR
cond_taken_e  input  1  ALU branch condition result
target_e  input  DATA_WIDTH  computed target (PC+imm or rs1+imm, bit0 cleared)
mispredict_e  output  1  E prediction was wrong
redirect_pc  output  DATA_WIDTH  corrected fetch PC; 0 when mispredict_e=0
flush_fd  output  1  clear F/D register
flush_de  output  1  clear D/E register
branch_count  output  DATA_WIDTH  resolved control-transfer instructions
mispredict_count  output  DATA_WIDTH  resolved mispredictions

Behaviour:
- Shadow registers:
  - D: valid_d, pc_d, ptaken_d, ptarget_d.
  - E: valid_e, pc_e, ptaken_e, ptarget_e.
- Next-state priority per edge, highest first:
  - rst: all valid and counters cleared to 0; pc/target fields cleared to 0.
  - mispredict_e=1: valid_d←0, valid_e←0 (flush beats stall).
  - stall_d=1: D holds; valid_e←0 (bubble).
  - Otherwise: D←F fields; E←D fields.
- Latency: a prediction entering with valid_f in cycle N is checked in E in cycle N+2 when no stall or flush occurs.
- Resolution (combinational from E regs and E inputs):
  - actual_taken = is_jal_e | is_jalr_e | (is_branch_e & cond_taken_e).
  - control = is_branch_e | is_jal_e | is_jalr_e.
  - mispredict_e = valid_e & ((actual_taken ≠ ptaken_e) | (actual_taken & ptaken_e & target_e ≠ ptarget_e)).
  - A non-control instruction predicted taken (ptaken_e=1) counts as a mispredict, with redirect to pc_e+4.
- redirect_pc:
  - mispredict_e=0: 0.
  - actual_taken: target_e.
  - otherwise: pc_e+4, modulo 2^DATA_WIDTH (wraps at 0xFFFFFFFC → 0x0).
- flush_fd = flush_de = mispredict_e.
- JALR is never predicted taken, so a valid JALR always mispredicts.
- Counters:
  - branch_count += 1 on each edge where valid_e & control.
  - mispredict_count += 1 on each edge where mispredict_e.
  - Both wrap modulo 2^DATA_WIDTH.
  - Both are registered outputs, updated the edge after resolution.
- Reset mid-operation: in-flight predictions are discarded. mispredict_e, flush_fd and flush_de are 0 from the first cycle after the reset edge until a new valid instruction reaches E.
- Simultaneous mispredict and stall_d: flush wins; D is cleared, not held.

Test Plan:
- Backward BEQ at pc 0x100, predicted taken to 0xF0, cond_taken_e=1, target_e=0xF0 → mispredict_e=0, no flush; branch_count 0→1.
- Forward BNE at pc 0x200, predicted not taken, cond_taken_e=1, target_e=0x240 → mispredict_e=1, redirect_pc=0x240, flush_fd=flush_de=1; mispredict_count=1 next cycle; valid_d and valid_e are 0 the next cycle.
- Backward BLT at pc 0x300, predicted taken, cond_taken_e=0 → redirect_pc=0x304, mispredict_e=1.
- JALR at pc 0x400, target_e=0x1000 → mispredict_e=1, redirect_pc=0x1000.
- Branch in D with stall_d=1 for 2 cycles → two bubbles in E with mispredict_e=0; the branch reaches E on the third cycle with its original pc and prediction.
- Mispredict in E while stall_d=1 → D cleared, not held. Separately, assert rst with a branch in D → valid_d=valid_e=0, counters 0, no flush after reset.
